// File: rtl/cache_line_mover.sv
// -----------------------------------------------------------------------------
// cache_line_mover
//
// Memory-side initiator for the cache subsystem. A whole-line refill or
// writeback request from the cache controller is turned into one single-word
// access per cycle on a synchronous word memory. The memory returns read data
// one cycle after the address is clocked.
//
// Optional feature macro: LINE_MOVER_CWF_EN
//   defined   : refills are critical-word-first, starting at i_req_word and
//               wrapping modulo the line size.
//   undefined : refills always run 0..N-1 and i_req_word is ignored.
//   Writebacks always run 0..N-1.
//
// Handshake: a request is accepted on a rising clk edge where
//   i_req_valid && o_req_ready. o_req_ready is high only in IDLE. Request
//   fields are latched on accept. Inputs are ignored while busy. The refill
//   stream has no backpressure, so the cache must take every beat.
//
// Ports
//   i_clk, i_rst       clock; asynchronous active-high reset
//   i_req_valid        cache requests a line transfer
//   o_req_ready        engine idle, a request can be accepted
//   i_req_write        1 = writeback, 0 = refill
//   i_req_line         line address (TAG_W bits)
//   i_req_word         critical word for refill (used only with the macro)
//   o_rf_valid         refill beat valid
//   o_rf_idx           word index of the current refill beat
//   o_rf_data          refill word (direct from memory read data)
//   o_wb_idx           word index the engine samples from the cache this cycle
//   i_wb_data          cache word at o_wb_idx (combinational, same cycle)
//   o_done             one-cycle pulse on the final beat
//   o_mem_addr         registered memory word address {line, word}
//   o_mem_wr_req       registered memory write strobe
//   o_mem_wr_data      registered memory write data
//   i_mem_rd_data      memory read data
//   o_dbg_state        current FSM state (0 IDLE, 1 RD, 2 WR)
// -----------------------------------------------------------------------------
module cache_line_mover #(
    parameter int ADDR_LEN      = 11,
    parameter int LINE_ADDR_LEN = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic                                i_req_write,
    input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]   i_req_line,
    input  logic [LINE_ADDR_LEN-1:0]            i_req_word,
    output logic                                o_rf_valid,
    output logic [LINE_ADDR_LEN-1:0]            o_rf_idx,
    output logic [31:0]                         o_rf_data,
    output logic [LINE_ADDR_LEN-1:0]            o_wb_idx,
    input  logic [31:0]                         i_wb_data,
    output logic                                o_done,
    output logic [ADDR_LEN-1:0]                 o_mem_addr,
    output logic                                o_mem_wr_req,
    output logic [31:0]                         o_mem_wr_data,
    input  logic [31:0]                         i_mem_rd_data,
    output logic [1:0]                          o_dbg_state
);

    localparam int TAG_W = ADDR_LEN - LINE_ADDR_LEN;

    // Word count of a full line, in counters one bit wider than the index.
    localparam logic [LINE_ADDR_LEN:0]   N_CNT     = {1'b1, {LINE_ADDR_LEN{1'b0}}};
    localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = {LINE_ADDR_LEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [TAG_W-1:0]           r_line;
    logic [ADDR_LEN-1:0]        r_mem_addr;
    logic                       r_mem_wr_req;
    logic [31:0]                r_mem_wr_data;

    // Refill: issue side drives the address, beat side trails it by one cycle.
    logic [LINE_ADDR_LEN-1:0]   r_issue_idx;
    logic [LINE_ADDR_LEN:0]     r_issue_cnt;
    logic [LINE_ADDR_LEN-1:0]   r_beat_idx;
    logic [LINE_ADDR_LEN-1:0]   r_beat_cnt;
    logic                       r_rf_valid;

    // Writeback: index presented to the cache and count of words sampled.
    logic [LINE_ADDR_LEN-1:0]   r_wb_idx;
    logic [LINE_ADDR_LEN:0]     r_wb_cnt;

    logic [LINE_ADDR_LEN-1:0]   w_start;
    logic                       w_done_rd;
    logic                       w_done_wr;

`ifdef LINE_MOVER_CWF_EN
    assign w_start = i_req_word;
`else
    assign w_start = '0;
    wire w_unused_req_word = ^i_req_word;
`endif

    // Final refill beat is the Nth valid beat; final writeback cycle is the
    // one where the Nth sampled word sits on the memory write port.
    assign w_done_rd = (r_state == ST_RD) && r_rf_valid && (r_beat_cnt == LAST_BEAT);
    assign w_done_wr = (r_state == ST_WR) && (r_wb_cnt == N_CNT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_nxt = i_req_write ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                o_done = w_done_rd;
                if (w_done_rd) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                o_done = w_done_wr;
                if (w_done_wr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line        <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_req  <= 1'b0;
            r_mem_wr_data <= '0;
            r_issue_idx   <= '0;
            r_issue_cnt   <= '0;
            r_beat_idx    <= '0;
            r_beat_cnt    <= '0;
            r_rf_valid    <= 1'b0;
            r_wb_idx      <= '0;
            r_wb_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_wr_req <= 1'b0;
                    r_rf_valid   <= 1'b0;
                    if (i_req_valid) begin
                        r_line <= i_req_line;
                        if (!i_req_write) begin
                            // First address goes out on the accept edge.
                            r_mem_addr  <= {i_req_line, w_start};
                            r_issue_idx <= w_start + 1'b1;
                            r_issue_cnt <= {{LINE_ADDR_LEN{1'b0}}, 1'b1};
                            r_beat_idx  <= w_start;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_wb_idx <= '0;
                            r_wb_cnt <= '0;
                        end
                    end
                end
                ST_RD: begin
                    // Index is LINE_ADDR_LEN wide, so it wraps inside the line.
                    if (r_issue_cnt != N_CNT) begin
                        r_mem_addr  <= {r_line, r_issue_idx};
                        r_issue_idx <= r_issue_idx + 1'b1;
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    r_rf_valid <= !w_done_rd;
                    if (r_rf_valid) begin
                        r_beat_idx <= r_beat_idx + 1'b1;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (r_wb_cnt != N_CNT) begin
                        r_mem_wr_req  <= 1'b1;
                        r_mem_wr_data <= i_wb_data;
                        r_mem_addr    <= {r_line, r_wb_idx};
                        r_wb_idx      <= r_wb_idx + 1'b1;
                        r_wb_cnt      <= r_wb_cnt + 1'b1;
                    end else begin
                        r_mem_wr_req <= 1'b0;
                    end
                end
                default: begin
                    r_mem_wr_req <= 1'b0;
                    r_rf_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rf_valid    = r_rf_valid;
    assign o_rf_idx      = r_beat_idx;
    assign o_rf_data     = i_mem_rd_data;
    assign o_wb_idx      = r_wb_idx;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wr_req  = r_mem_wr_req;
    assign o_mem_wr_data = r_mem_wr_data;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cache_line_mover.sv
module tb_cache_line_mover;

    localparam int N = 8;
`ifdef LINE_MOVER_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_line;
    logic [2:0]  req_word;
    logic        rf_valid;
    logic [2:0]  rf_idx;
    logic [31:0] rf_data;
    logic [2:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done;
    logic [10:0] mem_addr;
    logic        mem_wr_req;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic [1:0]  dbg_state;

    logic [31:0] wb_base;
    logic [31:0] ram [0:2047];

    int checks = 0;
    int errors = 0;

    cache_line_mover #(.ADDR_LEN(11), .LINE_ADDR_LEN(3)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_line    (req_line),
        .i_req_word    (req_word),
        .o_rf_valid    (rf_valid),
        .o_rf_idx      (rf_idx),
        .o_rf_data     (rf_data),
        .o_wb_idx      (wb_idx),
        .i_wb_data     (wb_data),
        .o_done        (done),
        .o_mem_addr    (mem_addr),
        .o_mem_wr_req  (mem_wr_req),
        .o_mem_wr_data (mem_wr_data),
        .i_mem_rd_data (mem_rd_data),
        .o_dbg_state   (dbg_state)
    );

    // ---------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word memory, read data one cycle after the address.
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] <= 32'(i) * 32'h10;
    end
    always @(posedge clk) begin
        if (mem_wr_req) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
    end

    // Cache side of the writeback: word i reads as wb_base + i.
    assign wb_data = wb_base + {29'b0, wb_idx};

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------- driver tasks
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},   {31'b0, req_ready},   32'd1);
        check({tag, "_rf_valid"},    {31'b0, rf_valid},    32'd0);
        check({tag, "_done"},        {31'b0, done},        32'd0);
        check({tag, "_mem_wr_req"},  {31'b0, mem_wr_req},  32'd0);
        check({tag, "_mem_addr"},    {21'b0, mem_addr},    32'd0);
        check({tag, "_mem_wr_data"}, mem_wr_data,          32'd0);
        check({tag, "_rf_idx"},      {29'b0, rf_idx},      32'd0);
        check({tag, "_wb_idx"},      {29'b0, wb_idx},      32'd0);
        check({tag, "_state"},       {30'b0, dbg_state},   32'd0);
    endtask

    // Refill of one line; leaves the bench at the negedge of cycle N+2.
    // With hold=1, req_valid stays high and req_line moves to next_line
    // while the engine is busy.
    task automatic do_refill(input logic [7:0] line, input logic [2:0] word,
                             input bit hold, input logic [7:0] next_line);
        logic [2:0]  start;
        logic [2:0]  w;
        logic [10:0] a;
        start     = CWF ? word : 3'd0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_line  = line;
        req_word  = word;
        tick;
        if (hold) begin
            req_line = next_line;
            req_word = 3'd5;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= N + 2; k++) begin
            if (k <= N) begin
                w = start + 3'(k - 1);
                a = {line, w};
                check($sformatf("rd_mem_addr k=%0d", k), {21'b0, mem_addr}, {21'b0, a});
            end
            check($sformatf("rd_rf_valid k=%0d", k), {31'b0, rf_valid},
                  {31'b0, (k >= 2 && k <= N + 1)});
            if (k >= 2 && k <= N + 1) begin
                w = start + 3'(k - 2);
                a = {line, w};
                check($sformatf("rd_rf_idx k=%0d", k), {29'b0, rf_idx}, {29'b0, w});
                check($sformatf("rd_rf_data k=%0d", k), rf_data, {17'b0, a, 4'b0});
            end
            check($sformatf("rd_done k=%0d", k), {31'b0, done}, {31'b0, (k == N + 1)});
            check($sformatf("rd_req_ready k=%0d", k), {31'b0, req_ready}, {31'b0, (k == N + 2)});
            check($sformatf("rd_wr_req k=%0d", k), {31'b0, mem_wr_req}, 32'd0);
            if (k < N + 2) tick;
        end
    endtask

    // Writeback of one line with cache words base+i.
    task automatic do_writeback(input logic [7:0] line, input logic [31:0] base);
        logic [10:0] a;
        wb_base   = base;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line  = line;
        req_word  = 3'd0;
        tick;
        req_valid = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            if (k <= N) begin
                check($sformatf("wb_idx k=%0d", k), {29'b0, wb_idx}, 32'(k - 1));
            end
            check($sformatf("wb_wr_req k=%0d", k), {31'b0, mem_wr_req},
                  {31'b0, (k >= 2 && k <= N + 1)});
            if (k >= 2 && k <= N + 1) begin
                a = {line, 3'(k - 2)};
                check($sformatf("wb_mem_addr k=%0d", k), {21'b0, mem_addr}, {21'b0, a});
                check($sformatf("wb_wr_data k=%0d", k), mem_wr_data, base + 32'(k - 2));
            end
            check($sformatf("wb_done k=%0d", k), {31'b0, done}, {31'b0, (k == N + 1)});
            check($sformatf("wb_req_ready k=%0d", k), {31'b0, req_ready}, {31'b0, (k == N + 2)});
            check($sformatf("wb_rf_valid k=%0d", k), {31'b0, rf_valid}, 32'd0);
            if (k < N + 2) tick;
        end
    endtask

    // ---------------------------------------------------- directed sequence
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_line  = 8'h00;
        req_word  = 3'd0;
        wb_base   = 32'h0;

        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        tick;

        // Refill line 0x05: addresses 0x28..0x2F, data 0x280..0x2F0.
        do_refill(8'h05, 3'd0, 1'b0, 8'h00);

        // Writeback line 0x02 with words 0xA0+i to 0x10..0x17.
        do_writeback(8'h02, 32'hA0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("ram_wb[0x%0h]", 16 + i), ram[11'h10 + 11'(i)], 32'hA0 + 32'(i));
        end
        check("ram_below_line", ram[11'h0F], 32'hF0);
        check("ram_above_line", ram[11'h18], 32'h180);

        // Top line, critical word 6: wraps inside 0x7F8..0x7FF.
        do_refill(8'hFF, 3'd6, 1'b0, 8'h00);

        // Back-to-back with req_valid held: second accept exactly at edge 10.
        do_refill(8'h05, 3'd2, 1'b1, 8'h06);
        do_refill(8'h06, 3'd0, 1'b0, 8'h00);

        // Reset just after the edge that writes word 2 of a writeback.
        wb_base   = 32'hB0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line  = 8'h03;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        check("abort_wr_req_c4", {31'b0, mem_wr_req}, 32'd1);
        check("abort_addr_c4", {21'b0, mem_addr}, 32'h1A);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals("abort");
        @(negedge clk);
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i <= 2) begin
                check($sformatf("ram_abort[%0d]", i), ram[11'h18 + 11'(i)], 32'hB0 + 32'(i));
            end else begin
                check($sformatf("ram_abort[%0d]", i), ram[11'h18 + 11'(i)],
                      (32'h18 + 32'(i)) * 32'h10);
            end
        end
        check("abort_ready_after", {31'b0, req_ready}, 32'd1);
        tick;
        do_refill(8'h10, 3'd0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
